// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for HLS dataflow/pipeline instances. It flags a blocking condition only after
// it has persisted for THRESHOLD cycles, captures its source, and times how long it lasts.
module hls_deadlock_monitor_param #(
  parameter  int N_AXIS    = 2,
  parameter  int N_INST    = 2,
  parameter  int THRESHOLD = 1,
  parameter  int CNT_W     = 8,
  parameter  int CYC_W     = 16,
  parameter  int STICKY    = 0,
  localparam int INST_W    = (N_INST > 0) ? N_INST : 1,
  localparam int SRC_W     = $clog2(N_AXIS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [INST_W-1:0] inst_idle_sigs,
  input  logic [INST_W-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              block_pending,
  output logic [SRC_W-1:0]  block_src,
  output logic [CYC_W-1:0]  block_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMING,
    ST_BLOCKED
  } state_e;

  localparam logic [CNT_W:0] THR_V = (CNT_W + 1)'(THRESHOLD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;

  logic             axis_any;
  logic             sub_all;
  logic             raw;
  logic [SRC_W-1:0] src_entry;
  logic [CNT_W:0]   cnt_inc;

  assign axis_any = |axis_block_sigs;

  // Sub-instances deadlock together only when none is still running and at least one is blocked.
  if (N_INST > 0) begin : g_sub
    assign sub_all = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
  end else begin : g_no_sub
    assign sub_all = 1'b0;
  end

  assign raw     = axis_any | sub_all;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  // Lowest-index stalled stream wins; N_AXIS marks a pure sub-instance deadlock.
  always_comb begin
    src_entry = SRC_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--) begin
      if (axis_block_sigs[i]) src_entry = SRC_W'(i);
    end
  end

  always_comb begin
    // NOTE: every *_d gets a hold default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    cyc_d   = cyc_q;

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      src_d   = '0;
      cyc_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (raw) begin
            if (THRESHOLD == 1) begin
              state_d = ST_BLOCKED;
              src_d   = src_entry;
              cyc_d   = CYC_W'(1);
            end else begin
              state_d = ST_ARMING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARMING: begin
          if (!raw) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == THR_V) begin
            state_d = ST_BLOCKED;
            cnt_d   = '0;
            src_d   = src_entry;
            cyc_d   = CYC_W'(1);
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        ST_BLOCKED: begin
          if ((STICKY == 0) && !raw) begin
            state_d = ST_IDLE;
          end else if (!(&cyc_q)) begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      cyc_q   <= cyc_d;
    end
  end

  assign block         = (state_q == ST_BLOCKED);
  assign block_pending = (state_q == ST_ARMING);
  assign block_src     = src_q;
  assign block_cycles  = cyc_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Drives four differently parameterised monitors from shared stimulus and scores each
// against a behavioural reference model through a queue of expected outputs.
module tb_hls_deadlock_monitor_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [1:0] axis;
  logic [1:0] idle;
  logic [1:0] iblk;

  logic [3:0]  dut_blk;
  logic [3:0]  dut_pend;
  logic [1:0]  dut_src [4];
  logic [15:0] dut_cyc [4];
  logic [3:0]  cyc_narrow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Instance 0: legacy single-cycle; 1: persistence; 2: sticky; 3: narrow cycle counter.
  localparam int THR    [4] = '{1, 4, 2, 1};
  localparam int STK    [4] = '{0, 0, 1, 0};
  localparam int CYCMAX [4] = '{65535, 65535, 65535, 15};

  hls_deadlock_monitor_param #(.THRESHOLD(1), .STICKY(0)) u_legacy (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .clear(clear), .block(dut_blk[0]), .block_pending(dut_pend[0]),
    .block_src(dut_src[0]), .block_cycles(dut_cyc[0]));

  hls_deadlock_monitor_param #(.THRESHOLD(4), .STICKY(0)) u_persist (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .clear(clear), .block(dut_blk[1]), .block_pending(dut_pend[1]),
    .block_src(dut_src[1]), .block_cycles(dut_cyc[1]));

  hls_deadlock_monitor_param #(.THRESHOLD(2), .STICKY(1)) u_sticky (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .clear(clear), .block(dut_blk[2]), .block_pending(dut_pend[2]),
    .block_src(dut_src[2]), .block_cycles(dut_cyc[2]));

  hls_deadlock_monitor_param #(.THRESHOLD(1), .STICKY(0), .CYC_W(4)) u_sat (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
    .inst_block_sigs(iblk), .clear(clear), .block(dut_blk[3]), .block_pending(dut_pend[3]),
    .block_src(dut_src[3]), .block_cycles(cyc_narrow));

  assign dut_cyc[3] = {12'd0, cyc_narrow};

  typedef struct packed {
    logic [1:0] st;   // 0 idle, 1 arming, 2 blocked
    int         cnt;
    logic [1:0] src;
    int         cyc;
  } mdl_t;

  typedef struct packed {
    logic [3:0]       blk;
    logic [3:0]       pend;
    logic [3:0][1:0]  src;
    logic [3:0][15:0] cyc;
  } exp_t;

  mdl_t mdl [4];
  exp_t sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int k, input logic rst, input logic clr,
                                input logic [1:0] ax, input logic [1:0] id, input logic [1:0] bl);
    mdl_t       n;
    logic       hit;
    logic [1:0] s;
    n   = m;
    hit = (ax != 2'b00) || (((id | bl) == 2'b11) && (bl != 2'b00));
    s   = ax[0] ? 2'd0 : (ax[1] ? 2'd1 : 2'd2);
    if (rst || clr) return '0;
    if (m.st == 2'd0) begin
      if (hit && THR[k] == 1) begin n.st = 2'd2; n.src = s; n.cyc = 1; end
      else if (hit)           begin n.st = 2'd1; n.cnt = 1; end
    end else if (m.st == 2'd1) begin
      if (!hit)                     begin n.st = 2'd0; n.cnt = 0; end
      else if (m.cnt + 1 == THR[k]) begin n.st = 2'd2; n.cnt = 0; n.src = s; n.cyc = 1; end
      else                          n.cnt = m.cnt + 1;
    end else begin
      if (STK[k] == 0 && !hit)     n.st  = 2'd0;
      else if (m.cyc < CYCMAX[k])  n.cyc = m.cyc + 1;
    end
    return n;
  endfunction

  // One clock: drive on the falling edge, push the model's prediction, score just after the rise.
  task automatic cycle(input logic rst, input logic clr, input logic [1:0] ax,
                       input logic [1:0] id, input logic [1:0] bl);
    exp_t e;
    exp_t g;
    @(negedge clock);
    reset = rst; clear = clr; axis = ax; idle = id; iblk = bl;
    for (int k = 0; k < 4; k++) begin
      mdl[k]    = step(mdl[k], k, rst, clr, ax, id, bl);
      e.blk[k]  = (mdl[k].st == 2'd2);
      e.pend[k] = (mdl[k].st == 2'd1);
      e.src[k]  = mdl[k].src;
      e.cyc[k]  = 16'(mdl[k].cyc);
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    g = sb.pop_front();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d.block", k),         32'(dut_blk[k]),  32'(g.blk[k]));
      check($sformatf("u%0d.block_pending", k), 32'(dut_pend[k]), 32'(g.pend[k]));
      check($sformatf("u%0d.block_src", k),     32'(dut_src[k]),  32'(g.src[k]));
      check($sformatf("u%0d.block_cycles", k),  32'(dut_cyc[k]),  32'(g.cyc[k]));
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) mdl[k] = '0;
    reset = 1'b1; clear = 1'b0; axis = '0; idle = '0; iblk = '0;

    cycle(1, 0, 2'b00, 2'b00, 2'b00);
    cycle(1, 0, 2'b00, 2'b00, 2'b00);
    check("reset.block", 32'(dut_blk[0]), 0);
    check("reset.cycles", 32'(dut_cyc[2]), 0);

    // Legacy single-cycle pulse on stream 1.
    cycle(0, 0, 2'b00, 2'b00, 2'b00);
    cycle(0, 0, 2'b10, 2'b00, 2'b00);
    check("legacy.block", 32'(dut_blk[0]), 1);
    check("legacy.src", 32'(dut_src[0]), 1);
    check("legacy.cycles", 32'(dut_cyc[0]), 1);
    cycle(0, 0, 2'b00, 2'b00, 2'b00);
    check("legacy.release", 32'(dut_blk[0]), 0);

    // Persistence: 3-cycle hold, 1 gap, 4-cycle hold.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2'b01, 2'b00, 2'b00);
      check("persist.hold1_pending", 32'(dut_pend[1]), 1);
      check("persist.hold1_block", 32'(dut_blk[1]), 0);
    end
    cycle(0, 0, 2'b00, 2'b00, 2'b00);
    check("persist.gap_pending", 32'(dut_pend[1]), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2'b01, 2'b00, 2'b00);
      check("persist.hold2_block_early", 32'(dut_blk[1]), 0);
    end
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("persist.hold2_block", 32'(dut_blk[1]), 1);
    check("persist.hold2_pending", 32'(dut_pend[1]), 0);

    // Sub-instance deadlock, then one instance resumes.
    cycle(0, 1, 2'b00, 2'b00, 2'b00);
    check("clear.sticky_block", 32'(dut_blk[2]), 0);
    cycle(0, 0, 2'b00, 2'b01, 2'b10);
    check("sub.block", 32'(dut_blk[0]), 1);
    check("sub.src", 32'(dut_src[0]), 2);
    cycle(0, 0, 2'b00, 2'b00, 2'b10);
    check("sub.release", 32'(dut_blk[0]), 0);

    // Sticky hold and clear.
    cycle(0, 1, 2'b00, 2'b00, 2'b00);
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("sticky.enter", 32'(dut_blk[2]), 1);
    check("sticky.enter_cycles", 32'(dut_cyc[2]), 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 2'b00, 2'b00, 2'b00);
    check("sticky.held", 32'(dut_blk[2]), 1);
    check("sticky.cycles", 32'(dut_cyc[2]), 11);
    cycle(0, 1, 2'b01, 2'b00, 2'b00);
    check("sticky.clear_block", 32'(dut_blk[2]), 0);
    check("sticky.clear_cycles", 32'(dut_cyc[2]), 0);
    check("sticky.clear_pending", 32'(dut_pend[2]), 0);
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("sticky.rearm", 32'(dut_pend[2]), 1);

    // Saturation of the narrow cycle counter.
    cycle(0, 1, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("sat.narrow", 32'(dut_cyc[3]), 15);
    check("sat.wide", 32'(dut_cyc[0]), 20);

    // Reset mid-BLOCKED, then mid-ARMING.
    cycle(1, 0, 2'b01, 2'b00, 2'b00);
    check("rst_blocked.block", 32'(dut_blk[0]), 0);
    check("rst_blocked.cycles", 32'(dut_cyc[3]), 0);
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("rst_arming.pending", 32'(dut_pend[1]), 1);
    cycle(1, 0, 2'b01, 2'b00, 2'b00);
    check("rst_arming.cleared", 32'(dut_pend[1]), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 2'b01, 2'b00, 2'b00);
      check("rst_arming.restart_early", 32'(dut_blk[1]), 0);
    end
    cycle(0, 0, 2'b01, 2'b00, 2'b00);
    check("rst_arming.restart_block", 32'(dut_blk[1]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
